price_feed_player: RTL and testbench

- Synthesizable, parametrised market-data replayer that drives the `latest_price` inputs of the trading core from an on-chip frame memory.
- Generalises the fixed 4-asset, Q8.8, fixed-interval price stimulus. Adds:
  - configurable asset count, width and depth;
  - programmable hold interval;
  - loop or one-shot mode;
  - a valid/ready handshake;
  - per-asset output saturation.
- Sits between a host config path and `trading_top`'s price inputs.

---
 rtl/hft_feed_pkg.sv | 22 ++
 rtl/price_sat.sv | 28 ++
 rtl/price_feed_player.sv | 155 +++++++++++++++
 tb/tb_price_feed_player.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_feed_pkg.sv
// Shared types and defaults for the price feed replayer.
package hft_feed_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } feed_state_t;

  localparam int DEF_N_ASSETS = 4;
  localparam int DEF_PRICE_W  = 16;
  localparam int DEF_P_MAX    = 32512;  // 127.0 in Q8.8
  localparam int DEF_P_MIN    = 0;

  // Convenience for benches building Q8.8 frames from decimal prices.
  function automatic logic signed [15:0] real_to_q88(input real r);
    return 16'($rtoi(r * 256.0));
  endfunction

endpackage

// File: rtl/price_sat.sv
// Single-asset signed clamp to [P_MIN, P_MAX] with a saturation flag.
module price_sat #(
  parameter int PRICE_W = 16,
  parameter int P_MAX   = 32512,
  parameter int P_MIN   = 0
) (
  input  logic signed [PRICE_W-1:0] din,
  output logic signed [PRICE_W-1:0] dout,
  output logic                      sat
);

  localparam logic signed [PRICE_W-1:0] MAXV = PRICE_W'(P_MAX);
  localparam logic signed [PRICE_W-1:0] MINV = PRICE_W'(P_MIN);

  // Clamp the incoming price; both compares are signed at PRICE_W.
  always_comb begin
    dout = din;
    sat  = 1'b0;
    if (din > MAXV) begin
      dout = MAXV;
      sat  = 1'b1;
    end else if (din < MINV) begin
      dout = MINV;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/price_feed_player.sv
// Frame-memory market data replayer driving latest_price with a
// valid/ready handshake, programmable hold and loop/one-shot modes.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | frame word read from memory
// PRESENT | frame offered, waiting for ready
// HOLD    | idle gap between frames
// DONE    | one-shot playback finished
module price_feed_player
  import hft_feed_pkg::*;
#(
  parameter int N_ASSETS = DEF_N_ASSETS,
  parameter int PRICE_W  = DEF_PRICE_W,
  parameter int DEPTH    = 64,
  parameter int HOLD_W   = 16,
  parameter int P_MAX    = DEF_P_MAX,
  parameter int P_MIN    = DEF_P_MIN,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic                         clk_100mhz,
  input  logic                         global_reset,
  input  logic                         cfg_wr_en,
  input  logic [AW-1:0]                cfg_wr_addr,
  input  logic [N_ASSETS*PRICE_W-1:0]  cfg_wr_data,
  input  logic [LW-1:0]                cfg_len,
  input  logic [HOLD_W-1:0]            hold_cycles,
  input  logic                         loop_en,
  input  logic                         start,
  input  logic                         stop,
  output logic signed [PRICE_W-1:0]    latest_price [0:N_ASSETS-1],
  output logic                         latest_price_valid,
  input  logic                         latest_price_ready,
  output logic [N_ASSETS-1:0]          sat_flags,
  output logic [AW-1:0]                frame_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  feed_state_t state, state_nxt;

  logic [N_ASSETS*PRICE_W-1:0] mem [0:DEPTH-1];
  logic [N_ASSETS*PRICE_W-1:0] rd_q;

  logic [AW-1:0]     idx, idx_nxt;
  logic [LW-1:0]     len_q;
  logic [HOLD_W-1:0] hold_q, cnt;
  logic              loop_q;

  logic idle_like, len_bad, last, start_ok, wr_ok, err_set;

  logic signed [PRICE_W-1:0] sat_val [N_ASSETS];
  logic [N_ASSETS-1:0]       sat_hit;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign len_bad   = (cfg_len == '0) || (cfg_len > LW'(DEPTH));
  assign last      = ({1'b0, idx} == (len_q - LW'(1)));
  assign start_ok  = idle_like && start && !len_bad;
  assign wr_ok     = cfg_wr_en && idle_like;
  assign err_set   = (idle_like && start && len_bad) || (cfg_wr_en && !idle_like);

  assign busy               = !idle_like;
  assign latest_price_valid = (state == S_PRESENT);

  for (genvar g = 0; g < N_ASSETS; g++) begin : g_sat
    price_sat #(
      .PRICE_W (PRICE_W),
      .P_MAX   (P_MAX),
      .P_MIN   (P_MIN)
    ) u_sat (
      .din  (rd_q[g*PRICE_W +: PRICE_W]),
      .dout (sat_val[g]),
      .sat  (sat_hit[g])
    );
  end

  // Next state and next frame index; stop overrides everything while busy.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_nxt = S_FETCH;
          idx_nxt   = '0;
        end
      end
      S_FETCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (latest_price_ready) state_nxt = S_HOLD;
      S_HOLD: begin
        if (cnt == '0) begin
          if (last && !loop_q) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_FETCH;
            idx_nxt   = last ? '0 : idx + AW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!idle_like && stop) begin
      state_nxt = S_IDLE;
      idx_nxt   = idx;
    end
  end

  // State, latched config, hold counter and presented outputs.
  always_ff @(posedge clk_100mhz or posedge global_reset) begin
    if (global_reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      len_q     <= '0;
      hold_q    <= '0;
      loop_q    <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      sat_flags <= '0;
      frame_idx <= '0;
      for (int i = 0; i < N_ASSETS; i++) latest_price[i] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (err_set) cfg_err <= 1'b1;
      if (start_ok) begin
        len_q  <= cfg_len;
        hold_q <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
        loop_q <= loop_en;
        done   <= 1'b0;
      end
      if (state == S_HOLD && state_nxt == S_DONE) done <= 1'b1;
      if (state == S_PRESENT && state_nxt == S_HOLD) begin
        cnt <= hold_q - HOLD_W'(1);
      end else if (state == S_HOLD && cnt != '0) begin
        cnt <= cnt - HOLD_W'(1);
      end
      if (state == S_FETCH && state_nxt == S_PRESENT) begin
        for (int i = 0; i < N_ASSETS; i++) latest_price[i] <= sat_val[i];
        sat_flags <= sat_hit;
        frame_idx <= idx;
      end
    end
  end

  // Frame memory: writes only when not playing; read data registered
  // against the upcoming index so it is ready during FETCH.
  always_ff @(posedge clk_100mhz) begin
    if (wr_ok) mem[cfg_wr_addr] <= cfg_wr_data;
    rd_q <= mem[idx_nxt];
  end

endmodule

// File: tb/tb_price_feed_player.sv
// Self-checking bench for price_feed_player: directed scenarios plus
// randomized one-shot playbacks checked against a timeline/clamp model.
module tb_price_feed_player;
  import hft_feed_pkg::*;

  logic        clk_100mhz = 1'b0;
  logic        global_reset;
  logic        cfg_wr_en;
  logic [5:0]  cfg_wr_addr;
  logic [63:0] cfg_wr_data;
  logic [6:0]  cfg_len;
  logic [15:0] hold_cycles;
  logic        loop_en, start, stop;
  logic signed [15:0] latest_price [0:3];
  logic        latest_price_valid, latest_price_ready;
  logic [3:0]  sat_flags;
  logic [5:0]  frame_idx;
  logic        busy, done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [15:0] mm [64][4];

  price_feed_player dut (
    .clk_100mhz         (clk_100mhz),
    .global_reset       (global_reset),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_wr_addr        (cfg_wr_addr),
    .cfg_wr_data        (cfg_wr_data),
    .cfg_len            (cfg_len),
    .hold_cycles        (hold_cycles),
    .loop_en            (loop_en),
    .start              (start),
    .stop               (stop),
    .latest_price       (latest_price),
    .latest_price_valid (latest_price_valid),
    .latest_price_ready (latest_price_ready),
    .sat_flags          (sat_flags),
    .frame_idx          (frame_idx),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] clampv(input logic signed [15:0] v);
    if (v > 16'sd32512) return 16'sd32512;
    if (v < 16'sd0) return 16'sd0;
    return v;
  endfunction

  function automatic logic signed [15:0] rnd_price();
    logic signed [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'(32511 + $urandom_range(0, 2));
      1:       v = 16'($urandom_range(0, 2)) - 16'sd1;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic step();
    @(negedge clk_100mhz);
  endtask

  task automatic wr_frame(input int a, input logic signed [15:0] p0, p1, p2, p3,
                          input bit model_upd);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 6'(a);
    cfg_wr_data = {p3, p2, p1, p0};
    step();
    cfg_wr_en   = 1'b0;
    if (model_upd) begin
      mm[a][0] = p0; mm[a][1] = p1; mm[a][2] = p2; mm[a][3] = p3;
    end
  endtask

  task automatic check_frame(input string tag, input int f);
    logic [3:0] ef;
    ef = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.price%0d", tag, i), latest_price[i], clampv(mm[f][i]));
      if (clampv(mm[f][i]) != mm[f][i]) ef[i] = 1'b1;
    end
    chk({tag, ".sat"}, sat_flags, ef);
    chk({tag, ".idx"}, frame_idx, f);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Cycle c counts negedges since start was raised; frame k is offered at
  // c = 2 + k*(H+2) and the run ends one hold after the last frame.
  task automatic run_oneshot(input string tag, input int len, input int hold);
    int h, p, done_c;
    bit ev;
    h = (hold == 0) ? 1 : hold;
    p = h + 2;
    done_c = 3 + (len - 1) * p + h;
    cfg_len = 7'(len);
    hold_cycles = 16'(hold);
    loop_en = 1'b0;
    latest_price_ready = 1'b1;
    start_pulse();
    for (int c = 1; c <= done_c + 2; c++) begin
      ev = (c >= 2) && ((c - 2) % p == 0) && ((c - 2) / p < len);
      chk({tag, ".valid"}, latest_price_valid, ev);
      if (ev) check_frame(tag, (c - 2) / p);
      chk({tag, ".done"}, done, c >= done_c);
      chk({tag, ".busy"}, busy, c < done_c);
      step();
    end
  endtask

  initial begin
    int w, len, hold;
    bit ev;
    global_reset = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    cfg_len = '0; hold_cycles = '0; loop_en = 1'b0;
    start = 1'b0; stop = 1'b0; latest_price_ready = 1'b0;
    step();
    chk("rst.valid", latest_price_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.cfg_err", cfg_err, 0);
    chk("rst.frame_idx", frame_idx, 0);
    chk("rst.sat", sat_flags, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst.price%0d", i), latest_price[i], 0);
    global_reset = 1'b0;
    step();

    // One-shot, in-range frames (127.0 sits exactly on the clamp).
    wr_frame(0, 16'sd25600, 16'sd10240, 16'sd12800, 16'sd15360, 1);
    wr_frame(1, 16'sd29440, 16'sd10240, 16'sd8704,  16'sd14080, 1);
    wr_frame(2, 16'sd32512, 16'sd7424,  16'sd9472,  16'sd14336, 1);
    run_oneshot("oneshot", 3, 4);

    // Saturation, including P_MAX+1 and P_MIN-1 boundaries.
    wr_frame(0, real_to_q88(127.5), real_to_q88(-5.0), real_to_q88(30.0), real_to_q88(40.0), 1);
    wr_frame(1, 16'sd32513, -16'sd1, 16'sd32512, 16'sd0, 1);
    run_oneshot("sat", 2, 1);

    // Randomized one-shot playbacks.
    for (int r = 0; r < 4; r++) begin
      len  = $urandom_range(1, 4);
      hold = $urandom_range(0, 5);
      for (int f = 0; f < len; f++)
        wr_frame(f, rnd_price(), rnd_price(), rnd_price(), rnd_price(), 1);
      run_oneshot($sformatf("rand%0d", r), len, hold);
    end

    // Backpressure: frame held stable until the handshake edge.
    cfg_len = 7'd2; hold_cycles = 16'd2; loop_en = 1'b0; latest_price_ready = 1'b0;
    start_pulse();
    w = 0;
    while (!latest_price_valid && w < 10) begin step(); w++; end
    chk("bp.valid_rise", latest_price_valid, 1);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("bp.valid_hold", latest_price_valid, 1);
      check_frame("bp.stable", 0);
    end
    latest_price_ready = 1'b1;
    for (int d = 1; d <= 3; d++) begin
      step();
      chk("bp.gap", latest_price_valid, 0);
    end
    step();
    chk("bp.next_valid", latest_price_valid, 1);
    check_frame("bp.next", 1);
    step(); step(); step();
    chk("bp.done", done, 1);

    // Loop wrap: period 3, indices alternate, done never set.
    cfg_len = 7'd2; hold_cycles = 16'd1; loop_en = 1'b1; latest_price_ready = 1'b1;
    start_pulse();
    for (int c = 1; c <= 20; c++) begin
      ev = (c >= 2) && ((c - 2) % 3 == 0);
      chk("loop.valid", latest_price_valid, ev);
      if (ev) check_frame("loop", ((c - 2) / 3) % 2);
      chk("loop.done", done, 0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("loop.stop_valid", latest_price_valid, 0);
    chk("loop.stop_busy", busy, 0);
    chk("loop.stop_done", done, 0);

    // Errors: bad length ignored, sticky until reset.
    cfg_len = 7'd0;
    start_pulse();
    chk("err.len0_flag", cfg_err, 1);
    chk("err.len0_busy", busy, 0);
    step();
    chk("err.len0_valid", latest_price_valid, 0);
    chk("err.len0_idle", busy, 0);
    global_reset = 1'b1; step(); global_reset = 1'b0;
    chk("err.cleared", cfg_err, 0);
    cfg_len = 7'd65;
    start_pulse();
    chk("err.len65_flag", cfg_err, 1);
    chk("err.len65_busy", busy, 0);
    global_reset = 1'b1; step(); global_reset = 1'b0;

    // Write while playing is dropped and flagged.
    cfg_len = 7'd1; hold_cycles = 16'd3; loop_en = 1'b1; latest_price_ready = 1'b1;
    start_pulse();
    step();
    chk("err.wr_busy", busy, 1);
    wr_frame(0, 16'sd1111, 16'sd2222, 16'sd3333, 16'sd4444, 0);
    chk("err.wr_flag", cfg_err, 1);
    stop = 1'b1; step(); stop = 1'b0;
    run_oneshot("err.mem", 1, 1);
    chk("err.sticky", cfg_err, 1);

    // stop + start together during PRESENT.
    cfg_len = 7'd2; hold_cycles = 16'd1; loop_en = 1'b1; latest_price_ready = 1'b0;
    start_pulse();
    step();
    chk("ss.present", latest_price_valid, 1);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("ss.valid", latest_price_valid, 0);
    chk("ss.busy", busy, 0);
    chk("ss.done", done, 0);
    step();
    chk("ss.stays_idle", busy, 0);

    // Asynchronous reset while in HOLD.
    cfg_len = 7'd2; hold_cycles = 16'd5; loop_en = 1'b0; latest_price_ready = 1'b1;
    start_pulse();
    step();
    step();
    chk("ar.in_hold_valid", latest_price_valid, 0);
    chk("ar.in_hold_busy", busy, 1);
    #2 global_reset = 1'b1;
    #1;
    chk("ar.valid", latest_price_valid, 0);
    chk("ar.busy", busy, 0);
    chk("ar.done", done, 0);
    chk("ar.cfg_err", cfg_err, 0);
    chk("ar.frame_idx", frame_idx, 0);
    chk("ar.sat", sat_flags, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("ar.price%0d", i), latest_price[i], 0);
    step();
    global_reset = 1'b0;
    step();
    chk("ar.idle_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
